led_flasher: RTL and testbench



---
 rtl/led_flasher_pkg.sv | 15 +
 rtl/sat_counter.sv | 42 ++++
 rtl/led_flasher.sv | 97 +++++++++
 tb/tb_led_flasher.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_flasher_pkg.sv
// Shared types and defaults for the LED flasher and its event queue.
package led_flasher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam int DEF_ON_TICKS  = 4;
    localparam int DEF_OFF_TICKS = 4;
    localparam int DEF_CNT_W     = 4;
    localparam int DEF_TMR_W     = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down event counter with a sticky drop flag.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat_drop
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] count_q, count_d;
    logic         drop_q, drop_d;

    always_comb begin
        count_d = count_q;
        drop_d  = drop_q;
        if (inc && !dec) begin
            if (count_q == MAX) drop_d = 1'b1;
            else count_d = count_q + 1'b1;
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign count    = count_q;
    assign sat_drop = drop_q;

endmodule

// File: rtl/led_flasher.sv
// Turns event pulses into tick-timed LED flashes, queueing overlaps.
module led_flasher
    import led_flasher_pkg::*;
#(
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int TMR_W     = DEF_TMR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             pulse,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_TICKS - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_TICKS - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             start;
    logic             have_evt;

    sat_counter #(.W(CNT_W)) u_queue (
        .clk      (clk),
        .reset    (reset),
        .inc      (pulse),
        .dec      (start),
        .count    (pending),
        .sat_drop (overflow)
    );

    assign have_evt = (pending != '0);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (have_evt) begin
                    start   = 1'b1;
                    state_d = ST_ON;
                    timer_d = '0;
                end
            end
            ST_ON: begin
                if (tick) begin
                    if (timer_q == ON_LAST) begin
                        state_d = ST_OFF;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (tick) begin
                    if (timer_q == OFF_LAST) begin
                        timer_d = '0;
                        // queued event chains straight into the next flash
                        if (have_evt) begin
                            start   = 1'b1;
                            state_d = ST_ON;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign led  = (state_q == ST_ON);
    assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_flasher.sv
// Directed checks of flash timing, queueing, saturation and reset.
module tb_led_flasher;

    logic       clk = 1'b0;
    logic       reset, tick, pulse;
    logic       led, busy, overflow;
    logic [3:0] pending;
    logic       s_led, s_busy, s_ovf;
    logic [1:0] s_pend;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    led_flasher u_dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .pulse    (pulse),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    led_flasher #(.CNT_W(2)) u_sat (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .pulse    (pulse),
        .led      (s_led),
        .busy     (s_busy),
        .pending  (s_pend),
        .overflow (s_ovf)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pulse = 1'b0;
        tick  = 1'b0;
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    function automatic int q_pend(int c);
        if (c == 0) return 0;
        if (c <= 2) return 1;
        if (c <= 9) return 2;
        if (c <= 17) return 1;
        return 0;
    endfunction

    function automatic bit q_led(int c);
        return (c >= 2 && c <= 5) || (c >= 10 && c <= 13) ||
               (c >= 18 && c <= 21);
    endfunction

    initial begin
        int sp[6];
        int tcnt, lcnt;
        sp = '{0, 1, 1, 2, 3, 3};

        do_reset();
        smp();
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pend", pending, 0);
        chk("rst_ovf", overflow, 0);

        // single flash
        do_reset();
        tick = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            pulse = (c == 0);
            smp();
            chk($sformatf("s_led%0d", c), led,
                (c >= 2 && c <= 5));
            chk($sformatf("s_busy%0d", c), busy,
                (c >= 2 && c <= 9));
            chk($sformatf("s_pend%0d", c), pending,
                (c == 1) ? 1 : 0);
            nxt();
        end

        // queued flashes, back to back
        do_reset();
        tick = 1'b1;
        for (int c = 0; c <= 27; c++) begin
            pulse = (c <= 2);
            smp();
            chk($sformatf("q_led%0d", c), led, q_led(c));
            chk($sformatf("q_busy%0d", c), busy,
                (c >= 2 && c <= 25));
            chk($sformatf("q_pend%0d", c), pending, q_pend(c));
            nxt();
        end

        // saturation on the narrow instance
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            pulse = (c <= 4);
            smp();
            chk($sformatf("sat_pend%0d", c), s_pend, sp[c]);
            chk($sformatf("sat_ovf%0d", c), s_ovf, (c == 5));
            nxt();
        end
        pulse = 1'b0;
        smp();
        chk("sat_led", s_led, 1);
        chk("sat_ovf_hold", s_ovf, 1);
        chk("wide_no_ovf", overflow, 0);

        // tick every 8th cycle
        do_reset();
        tcnt = 0;
        lcnt = 0;
        for (int c = 0; c <= 50; c++) begin
            pulse = (c == 0);
            tick  = (c % 8 == 0);
            smp();
            if (led && tick) tcnt++;
            if (led) lcnt++;
            nxt();
        end
        chk("gate_ticks", tcnt, 4);
        chk("gate_lcyc", lcnt, 31);

        // no ticks: LED holds
        do_reset();
        lcnt = 0;
        for (int c = 0; c <= 101; c++) begin
            pulse = (c == 0);
            smp();
            if (led) lcnt++;
            nxt();
        end
        smp();
        chk("hold_lcyc", lcnt, 100);
        chk("hold_led", led, 1);

        // reset mid-flash with a simultaneous pulse
        do_reset();
        for (int c = 0; c <= 2; c++) begin
            pulse = 1'b1;
            nxt();
        end
        pulse = 1'b0;
        smp();
        chk("mr_pend2", pending, 2);
        chk("mr_led1", led, 1);
        reset = 1'b1;
        pulse = 1'b1;
        tick  = 1'b1;
        nxt();
        smp();
        chk("mr_led", led, 0);
        chk("mr_busy", busy, 0);
        chk("mr_pend", pending, 0);
        chk("mr_ovf", overflow, 0);
        reset = 1'b0;
        pulse = 1'b0;
        lcnt  = 0;
        for (int c = 0; c < 20; c++) begin
            nxt();
            smp();
            if (led || busy) lcnt++;
        end
        chk("mr_quiet", lcnt, 0);

        // pulse on the final OFF tick
        do_reset();
        tick = 1'b1;
        for (int c = 0; c <= 19; c++) begin
            pulse = (c == 0 || c == 9);
            smp();
            if (c == 9) begin
                chk("lo_busy9", busy, 1);
                chk("lo_pend9", pending, 0);
            end
            if (c == 10) begin
                chk("lo_busy10", busy, 0);
                chk("lo_pend10", pending, 1);
            end
            if (c == 11) begin
                chk("lo_led11", led, 1);
                chk("lo_pend11", pending, 0);
            end
            if (c == 19) begin
                chk("lo_busy19", busy, 0);
                chk("lo_pend19", pending, 0);
            end
            nxt();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
